// File: rtl/st7735_spi_tx.sv
// Write-only SPI byte transmitter for an ST7735 panel: mode 0, MSB first, with a
// registered D/C line and a chip select held low across back-to-back bytes.
module st7735_spi_tx #(
   parameter int CLK_DIV = 2,
   parameter int CS_HOLD = 4
) (
   input  logic       SYSTEM_CLK,
   input  logic       RESET_N,
   input  logic [7:0] TX_DATA,
   input  logic       TX_DC,
   input  logic       TX_VALID,
   output logic       TX_READY,
   output logic       BUSY,
   output logic       CS,
   output logic       MOSI,
   output logic       DC,
   output logic       LCD_CLK
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);

   state_t     r_state;
   logic [7:0] r_shreg;
   logic [7:0] r_half;
   logic [2:0] r_bit;
   logic       r_cs;
   logic       r_busy;
   logic       r_mosi;
   logic       r_dc;
   logic       r_lclk;
   logic       w_xfer;

   assign TX_READY = RESET_N && (r_state != S_SHIFT);
   assign w_xfer   = TX_VALID && TX_READY;

   assign BUSY    = r_busy;
   assign CS      = r_cs;
   assign MOSI    = r_mosi;
   assign DC      = r_dc;
   assign LCD_CLK = r_lclk;

   // r_half counts half-periods while shifting and idle hold cycles in HOLD.
   always_ff @(posedge SYSTEM_CLK) begin
      if (!RESET_N) begin
         r_state <= S_IDLE;
         r_shreg <= 8'h00;
         r_half  <= 8'h00;
         r_bit   <= 3'd0;
         r_cs    <= 1'b1;
         r_busy  <= 1'b0;
         r_mosi  <= 1'b0;
         r_dc    <= 1'b0;
         r_lclk  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_HOLD: begin
               if (w_xfer) begin
                  r_state <= S_SHIFT;
                  r_shreg <= TX_DATA;
                  r_dc    <= TX_DC;
                  r_cs    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_mosi  <= TX_DATA[7];
                  r_lclk  <= 1'b0;
                  r_half  <= 8'h00;
                  r_bit   <= 3'd7;
               end else if (r_state == S_HOLD) begin
                  if (r_half == HOLD_LAST) begin
                     r_state <= S_IDLE;
                     r_cs    <= 1'b1;
                     r_busy  <= 1'b0;
                     r_half  <= 8'h00;
                  end else begin
                     r_half <= r_half + 8'h01;
                  end
               end
            end
            S_SHIFT: begin
               if (r_half != HALF_LAST) begin
                  r_half <= r_half + 8'h01;
               end else begin
                  r_half <= 8'h00;
                  if (!r_lclk) begin
                     r_lclk <= 1'b1;
                  end else begin
                     // Falling edge: advance to the next bit, or finish the byte.
                     r_lclk <= 1'b0;
                     if (r_bit == 3'd0) begin
                        r_state <= S_HOLD;
                     end else begin
                        r_bit   <= r_bit - 3'd1;
                        r_shreg <= {r_shreg[6:0], 1'b0};
                        r_mosi  <= r_shreg[6];
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cs    <= 1'b1;
               r_busy  <= 1'b0;
               r_lclk  <= 1'b0;
               r_half  <= 8'h00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_st7735_spi_tx.sv
// Bench for st7735_spi_tx: two instances (CLK_DIV=2/CS_HOLD=4 and CLK_DIV=1/CS_HOLD=2)
// checked cycle by cycle against closed-form expectations of the serial waveform.
module tb_st7735_spi_tx;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] data;
   logic       dc;
   logic       v;
   logic       sel;
   logic       v0, v1;

   logic rdy0, busy0, cs0, mosi0, dc0, lclk0;
   logic rdy1, busy1, cs1, mosi1, dc1, lclk1;
   logic s_rdy, s_busy, s_cs, s_mosi, s_dc, s_lclk;

   int nvec = 0;
   int nerr = 0;

   assign v0 = v & ~sel;
   assign v1 = v & sel;

   always_comb begin
      s_rdy  = sel ? rdy1  : rdy0;
      s_busy = sel ? busy1 : busy0;
      s_cs   = sel ? cs1   : cs0;
      s_mosi = sel ? mosi1 : mosi0;
      s_dc   = sel ? dc1   : dc0;
      s_lclk = sel ? lclk1 : lclk0;
   end

   st7735_spi_tx #(.CLK_DIV(2), .CS_HOLD(4)) dut0 (
      .SYSTEM_CLK(clk), .RESET_N(rst_n), .TX_DATA(data), .TX_DC(dc), .TX_VALID(v0),
      .TX_READY(rdy0), .BUSY(busy0), .CS(cs0), .MOSI(mosi0), .DC(dc0), .LCD_CLK(lclk0));

   st7735_spi_tx #(.CLK_DIV(1), .CS_HOLD(2)) dut1 (
      .SYSTEM_CLK(clk), .RESET_N(rst_n), .TX_DATA(data), .TX_DC(dc), .TX_VALID(v1),
      .TX_READY(rdy1), .BUSY(busy1), .CS(cs1), .MOSI(mosi1), .DC(dc1), .LCD_CLK(lclk1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cs"},   32'(s_cs),   32'd1);
      chk({tag, "_lclk"}, 32'(s_lclk), 32'd0);
      chk({tag, "_mosi"}, 32'(s_mosi), 32'd0);
      chk({tag, "_dc"},   32'(s_dc),   32'd0);
      chk({tag, "_busy"}, 32'(s_busy), 32'd0);
      chk({tag, "_rdy"},  32'(s_rdy),  32'd0);
   endtask

   // Called at a negedge of a cycle in which the selected instance is ready.
   // The byte is accepted at the end of that cycle; shift cycles and `gap`
   // following cycles are then checked. Expected waveform: bit n occupies
   // 2*D cycles (low D, high D), CS stays low for H idle cycles after the byte.
   task automatic xfer(input logic [7:0] b, input logic d, input int gap);
      int         D, H, rises;
      logic [7:0] got;
      logic       plc;
      D = sel ? 1 : 2;
      H = sel ? 2 : 4;
      data = b;
      dc   = d;
      v    = 1'b1;
      chk("ready_at_xfer", 32'(s_rdy), 32'd1);
      @(posedge clk);
      #1 v = 1'b0;
      rises = 0;
      got   = 8'h00;
      plc   = 1'b0;
      for (int c = 1; c <= 16 * D; c++) begin
         @(negedge clk);
         chk("shift_cs",   32'(s_cs),   32'd0);
         chk("shift_busy", 32'(s_busy), 32'd1);
         chk("shift_rdy",  32'(s_rdy),  32'd0);
         chk("shift_dc",   32'(s_dc),   32'(d));
         chk("shift_lclk", 32'(s_lclk), 32'(((c - 1) / D) % 2));
         chk("shift_mosi", 32'(s_mosi), 32'(b[7 - (c - 1) / (2 * D)]));
         if (s_lclk && !plc) begin
            rises++;
            got = {got[6:0], s_mosi};
         end
         plc  = s_lclk;
         // Garbage on the inputs while busy must not leak into MOSI/DC.
         data = 8'($urandom);
         dc   = 1'($urandom);
         v    = (c < 16 * D) ? 1'($urandom) : 1'b0;
      end
      chk("rise_count", 32'(rises), 32'd8);
      chk("rise_byte",  32'(got),   32'(b));
      for (int j = 1; j <= gap; j++) begin
         @(negedge clk);
         chk("hold_cs",   32'(s_cs),   (j <= H) ? 32'd0 : 32'd1);
         chk("hold_busy", 32'(s_busy), (j <= H) ? 32'd1 : 32'd0);
         chk("hold_rdy",  32'(s_rdy),  32'd1);
         chk("hold_lclk", 32'(s_lclk), 32'd0);
         chk("hold_mosi", 32'(s_mosi), 32'(b[0]));
         chk("hold_dc",   32'(s_dc),   32'(d));
      end
   endtask

   initial begin
      int h, gap;
      rst_n = 1'b0;
      data  = 8'hFF;
      dc    = 1'b1;
      v     = 1'b1;
      sel   = 1'b0;

      // Reset held with TX_VALID high: nothing may be accepted.
      repeat (3) begin
         @(negedge clk);
         chk_reset("reset0");
         sel = 1'b1;
         chk_reset("reset1");
         sel = 1'b0;
      end
      rst_n = 1'b1;
      v     = 1'b0;
      #1;
      chk("post_reset_rdy", 32'(s_rdy), 32'd1);
      chk("post_reset_cs",  32'(s_cs),  32'd1);

      // Single byte; CS must release on the 5th cycle after the byte.
      xfer(8'hA5, 1'b0, 6);

      // Back-to-back: second byte accepted on the first HOLD cycle.
      xfer(8'h2C, 1'b0, 1);
      xfer(8'hFF, 1'b1, 6);

      // Abort mid-byte, then a clean byte from bit 7.
      data = 8'h5A;
      dc   = 1'b1;
      v    = 1'b1;
      @(posedge clk);
      #1 v = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset("midbyte_reset");
      rst_n = 1'b1;
      #1;
      xfer(8'h3C, 1'b0, 6);

      // Maximum rate instance.
      sel = 1'b1;
      #1;
      xfer(8'h81, 1'b1, 4);

      // Random bytes, instances and gaps (gaps both inside and beyond CS hold).
      repeat (40) begin
         sel = 1'($urandom);
         #1;
         h   = sel ? 2 : 4;
         gap = int'($urandom_range(1, h + 2));
         xfer(8'($urandom), 1'($urandom), gap);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/st7735_spi_tx.md
ST7735_SPI_TX -- requirements
Module: st7735_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SYSTEM_CLK cycles per LCD_CLK half-period, legal range 1..255.
REQ-002 SHALL have parameter CS_HOLD, default 4: idle SYSTEM_CLK cycles CS stays low after a byte before release, legal range 1..255.
REQ-003 SHALL have port SYSTEM_CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port TX_DATA  input  8  byte to send, MSB first.
REQ-006 SHALL have port TX_DC  input  1  data/command flag for TX_DATA (0 = command, 1 = data).
REQ-007 SHALL have port TX_VALID  input  1  upstream offers TX_DATA/TX_DC.
REQ-008 SHALL have port TX_READY  output  1  block can accept a byte this cycle.
REQ-009 SHALL have port BUSY  output  1  high whenever CS is low.
REQ-010 SHALL have port CS  output  1  panel chip select, active-low.
REQ-011 SHALL have port MOSI  output  1  serial data to panel.
REQ-012 SHALL have port DC  output  1  registered data/command line to panel.
REQ-013 SHALL have port LCD_CLK  output  1  SPI clock, mode 0 (idle low, panel samples on rising edge).

Function
REQ-014 SHALL implement states IDLE, SHIFT, HOLD; all outputs except TX_READY registered.
REQ-015 SHALL drive TX_READY = 1 exactly when RESET_N = 1 and state is IDLE or HOLD; transfer occurs on an edge where TX_VALID and TX_READY are both 1.
REQ-016 On transfer at edge k SHALL, from cycle k+1: latch TX_DATA into shift register, set DC = TX_DC, CS = 0, MOSI = TX_DATA[7], LCD_CLK = 0, state SHIFT.
REQ-017 In SHIFT each bit SHALL occupy 2*CLK_DIV cycles: LCD_CLK low for CLK_DIV cycles, then high for CLK_DIV cycles; MOSI changes only on the cycle LCD_CLK returns low.
REQ-018 A byte SHALL occupy exactly 16*CLK_DIV cycles (k+1 .. k+16*CLK_DIV), bits 7 down to 0; then state HOLD with LCD_CLK = 0.
REQ-019 In HOLD, a transfer SHALL start the next byte per REQ-016 with CS held low continuously (no CS pulse between back-to-back bytes).
REQ-020 In HOLD without transfer for CS_HOLD consecutive cycles, CS SHALL go high on the following cycle and state return to IDLE.
REQ-021 TX_DATA/TX_DC changes outside a transfer edge SHALL NOT affect MOSI or DC.
REQ-022 DC SHALL change only at a transfer edge and hold its value until the next transfer, including through HOLD and IDLE.
REQ-023 MOSI SHALL hold the last-shifted bit in HOLD and IDLE.
REQ-024 BUSY SHALL equal ~CS every cycle.
REQ-025 Internal counters SHALL be 8-bit half-period counter and 3-bit bit index; no wrap-around beyond defined ranges.

Reset
REQ-026 With RESET_N = 0 at an edge, next cycle SHALL have CS = 1, LCD_CLK = 0, MOSI = 0, DC = 0, BUSY = 0, state IDLE, counters 0; TX_READY = 0 while RESET_N = 0.
REQ-027 Reset mid-byte or in HOLD SHALL abort immediately per REQ-026; the partial byte is discarded and not resumed.
REQ-028 First cycle with RESET_N = 1 SHALL show TX_READY = 1 (IDLE).

Verification
REQ-029 Reset: hold RESET_N low 3 cycles with TX_VALID = 1 -> CS=1, LCD_CLK=0, MOSI=0, DC=0, TX_READY=0; no transfer.
REQ-030 Single byte, CLK_DIV=2, CS_HOLD=4: 0xA5, TX_DC=0 accepted at cycle 0 -> CS low cycles 1..36, LCD_CLK rises at cycles 3,7,..,31, MOSI sampled at rises = 1,0,1,0,0,1,0,1, DC=0, CS high at cycle 37, TX_READY high cycles 33..36 and from 37.
REQ-031 Back-to-back: 0x2C DC=0 then 0xFF DC=1 valid from cycle 1 -> second accepted at cycle 33, DC=1 from cycle 34 with LCD_CLK low, CS never high between bytes, 16 rising edges total.
REQ-032 Reset mid-byte: RESET_N low at cycle 10 of a byte -> CS=1, LCD_CLK=0 at cycle 11; after release new byte 0x3C transmits correctly from bit 7.
REQ-033 Stability: TX_DATA toggled every cycle while in SHIFT -> MOSI equals latched byte only; TX_READY=0 throughout SHIFT.
REQ-034 Max rate CLK_DIV=1: 0x81 DC=1 -> 16-cycle byte, LCD_CLK = SYSTEM_CLK/2, MOSI 1,0,0,0,0,0,0,1 at rises.
